// File: rtl/oled_i2c_pkg.sv
// Shared definitions for the OLED I2C write path: FSM encodings, default
// slave address, control bytes and the per-quarter bus level table.
package oled_i2c_pkg;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_ADDR  = 4'd2;
  localparam logic [3:0] S_ACK1  = 4'd3;
  localparam logic [3:0] S_WADDR = 4'd4;
  localparam logic [3:0] S_ACK2  = 4'd5;
  localparam logic [3:0] S_DATA  = 4'd6;
  localparam logic [3:0] S_ACK3  = 4'd7;
  localparam logic [3:0] S_STOP  = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE  = S_IDLE,
    ST_START = S_START,
    ST_ADDR  = S_ADDR,
    ST_ACK1  = S_ACK1,
    ST_WADDR = S_WADDR,
    ST_ACK2  = S_ACK2,
    ST_DATA  = S_DATA,
    ST_ACK3  = S_ACK3,
    ST_STOP  = S_STOP
  } state_t;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h3C;
  localparam logic [7:0] CMD_CTRL     = 8'h00;
  localparam logic [7:0] DATA_CTRL    = 8'h40;

  // Returns {scl, sda_low} for a given state/quarter; b is the data bit.
  function automatic logic [1:0] bus_level(state_t st, logic [1:0] q, logic b);
    logic [1:0] lv;
    lv = 2'b10;
    case (st)
      ST_START: lv = {1'b1, q[1]};
      ST_ADDR, ST_WADDR, ST_DATA: lv = {q[1], ~b};
      ST_ACK1, ST_ACK2, ST_ACK3: lv = {q[1], 1'b0};
      ST_STOP: begin
        case (q)
          2'd0:    lv = 2'b01;
          2'd1:    lv = 2'b11;
          default: lv = 2'b10;
        endcase
      end
      default: lv = 2'b10;
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-bit timebase: counts 0..DIV-1 and flags the last count.
module i2c_qtick #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_reg;

  assign tick = (cnt_reg == W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/oled_i2c_wr.sv
// Single-byte I2C write master: START, {DEV_ADDR,W}, word address, data, STOP.
// Define OLED_I2C_NACK_ABORT_EN to end the frame with STOP on the first NACK.
module oled_i2c_wr
  import oled_i2c_pkg::*;
#(
  parameter int         CLK_FREQ = 50_000_000,
  parameter int         I2C_FREQ = 250_000,
  parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       exec,
  input  logic [7:0] word_addr,
  input  logic [7:0] wdata,
  output logic       i2c_done,
  output logic       i2c_err,
  output logic       busy,
  output logic       scl,
  inout  wire        sda
);

  localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);

  state_t     state_reg, state_next;
  logic [1:0] q_reg, q_next;
  logic [2:0] bit_reg, bit_next;
  logic [7:0] waddr_reg, wdata_reg, tx_byte;
  logic       scl_reg, sda_low_reg, busy_reg, done_reg, err_reg;
  logic       tick, accept, is_ack, nack_stop;

  assign accept = (state_reg == ST_IDLE) && exec;
  assign is_ack = (state_reg == ST_ACK1) || (state_reg == ST_ACK2) || (state_reg == ST_ACK3);

`ifdef OLED_I2C_NACK_ABORT_EN
  assign nack_stop = err_reg;
`else
  assign nack_stop = 1'b0;
`endif

  i2c_qtick #(.DIV(DIV)) u_qtick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .tick  (tick)
  );

  // Position of the next quarter; only consumed on a tick.
  always_comb begin
    state_next = state_reg;
    q_next     = q_reg + 2'd1;
    bit_next   = bit_reg;
    if (q_reg == 2'd3) begin
      case (state_reg)
        ST_START: begin
          state_next = ST_ADDR;
          bit_next   = 3'd7;
        end
        ST_ADDR, ST_WADDR, ST_DATA: begin
          if (bit_reg == 3'd0) begin
            state_next = (state_reg == ST_ADDR)  ? ST_ACK1 :
                         (state_reg == ST_WADDR) ? ST_ACK2 : ST_ACK3;
          end else begin
            bit_next = bit_reg - 3'd1;
          end
        end
        ST_ACK1: begin
          state_next = nack_stop ? ST_STOP : ST_WADDR;
          bit_next   = 3'd7;
        end
        ST_ACK2: begin
          state_next = nack_stop ? ST_STOP : ST_DATA;
          bit_next   = 3'd7;
        end
        ST_ACK3: state_next = ST_STOP;
        default: state_next = state_reg;
      endcase
    end
    case (state_next)
      ST_ADDR:  tx_byte = {DEV_ADDR, 1'b0};
      ST_WADDR: tx_byte = waddr_reg;
      ST_DATA:  tx_byte = wdata_reg;
      default:  tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      q_reg       <= 2'd0;
      bit_reg     <= 3'd7;
      waddr_reg   <= 8'h00;
      wdata_reg   <= 8'h00;
      scl_reg     <= 1'b1;
      sda_low_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == ST_IDLE) begin
        if (exec) begin
          waddr_reg   <= word_addr;
          wdata_reg   <= wdata;
          busy_reg    <= 1'b1;
          err_reg     <= 1'b0;
          state_reg   <= ST_START;
          q_reg       <= 2'd0;
          bit_reg     <= 3'd7;
          {scl_reg, sda_low_reg} <= bus_level(ST_START, 2'd0, 1'b1);
        end
      end else if (state_reg == ST_STOP && done_reg) begin
        // STOP is held through the done cycle so a same-cycle exec is refused.
        state_reg <= ST_IDLE;
      end else if (tick) begin
        if (is_ack && q_reg == 2'd2 && sda !== 1'b0) begin
          err_reg <= 1'b1;
        end
        if (state_reg == ST_STOP && q_reg == 2'd3) begin
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          q_reg     <= q_next;
          bit_reg   <= bit_next;
          {scl_reg, sda_low_reg} <= bus_level(state_next, q_next, tx_byte[bit_next]);
        end
      end
    end
  end

  assign scl      = scl_reg;
  assign sda      = sda_low_reg ? 1'b0 : 1'bz;
  assign busy     = busy_reg;
  assign i2c_done = done_reg;
  assign i2c_err  = err_reg;

endmodule

// File: tb/tb_oled_i2c_wr.sv
// Self-checking bench for oled_i2c_wr: an I2C slave decodes the bus and a
// frame-level model predicts bytes, done timing and the NACK flag.
module tb_oled_i2c_wr;
  import oled_i2c_pkg::*;

  localparam int DIV = 5;
  localparam int CLK_FREQ = 5_000_000;
  localparam int I2C_FREQ = 250_000;
`ifdef OLED_I2C_NACK_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, exec = 1'b0;
  logic [7:0] word_addr = 8'h00, wdata = 8'h00;
  wire i2c_done, i2c_err, busy, scl, sda;
  logic slave_low = 1'b0;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  oled_i2c_wr #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ), .DEV_ADDR(7'h3C)) dut (
    .clk(clk), .rst_n(rst_n), .exec(exec), .word_addr(word_addr), .wdata(wdata),
    .i2c_done(i2c_done), .i2c_err(i2c_err), .busy(busy), .scl(scl), .sda(sda)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int frames = 0, done_cnt = 0, nack_idx = -1;
  int bitcnt = 0;
  logic [7:0] sr = 8'h00;
  logic [7:0] rx_q[$];
  logic [7:0] last_frame[$];
  logic prev_scl = 1'b1, prev_sda = 1'b1;

  // Slave: decodes START/STOP/bytes and ACKs every byte except nack_idx.
  always @(negedge clk) begin
    if (!rst_n) slave_low = 1'b0;
    if (scl && prev_scl && prev_sda && !sda) begin
      bitcnt = 0;
      rx_q.delete();
    end else if (scl && prev_scl && !prev_sda && sda) begin
      last_frame = rx_q;
      frames++;
    end else if (scl && !prev_scl) begin
      if (bitcnt == 8) begin
        rx_q.push_back(sr);
        bitcnt = 0;
      end else begin
        sr = {sr[6:0], sda};
        bitcnt++;
      end
    end else if (!scl && prev_scl) begin
      slave_low = (bitcnt == 8) && (rx_q.size() != nack_idx);
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  always @(posedge clk) if (i2c_done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame; caller is at a negedge. Window k after the accepting edge E0
  // is the cycle sampled by edge E0+k.
  task automatic xfer(input logic [7:0] wa, input logic [7:0] wd, input int nack,
                      input int poke_at, input bit exec_on_done);
    int cyc, done_at, f0, d0, exp_done, nbytes;
    logic [7:0] exp_bytes[$];
    nack_idx = nack;
    f0 = frames;
    d0 = done_cnt;
    word_addr = wa;
    wdata = wd;
    exec = 1'b1;
    @(negedge clk);
    exec = 1'b0;
    cyc = 1;
    chk("busy_rise", busy, 1);
    chk("err_clear", i2c_err, 0);
    done_at = 0;
    while (cyc < 200 * DIV) begin
      if (i2c_done) begin
        done_at = cyc;
        break;
      end
      if (cyc == poke_at) begin
        exec = 1'b1;
        word_addr = ~wa;
        wdata = ~wd;
      end else begin
        exec = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    exp_bytes = '{8'h78, wa, wd};
    if (ABORT && nack >= 0 && nack <= 2) begin
      nbytes = nack + 1;
      exp_done = 4 * (1 + 9 * nbytes + 1) * DIV + 1;
    end else begin
      nbytes = 3;
      exp_done = 116 * DIV + 1;
    end
    chk("done_time", done_at, exp_done);
    chk("busy_at_done", busy, 0);
    chk("err_at_done", i2c_err, (nack >= 0 && nack <= 2) ? 1 : 0);
    if (exec_on_done) begin
      exec = 1'b1;
      word_addr = ~wa;
      wdata = ~wd;
    end
    @(negedge clk);
    exec = 1'b0;
    chk("done_one_cycle", i2c_done, 0);
    chk("one_done_pulse", done_cnt - d0, 1);
    chk("one_frame", frames - f0, 1);
    chk("frame_len", last_frame.size(), nbytes);
    for (int i = 0; i < nbytes && i < last_frame.size(); i++)
      chk($sformatf("byte%0d", i), last_frame[i], exp_bytes[i]);
    if (exec_on_done) begin
      chk("same_cycle_exec_refused", busy, 0);
      repeat (3 * DIV) @(negedge clk);
      chk("refused_no_frame", frames - f0, 1);
      chk("refused_idle", busy, 0);
    end
    $display("xfer wa=%02h wd=%02h nack=%0d done_at=%0d bytes=%0d", wa, wd, nack, done_at, last_frame.size());
  endtask

  initial begin
    logic [7:0] wa, wd;
    int d0;
    repeat (3) @(negedge clk);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", i2c_done, 0);
    chk("rst_err", i2c_err, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (scl !== 1'b1 || sda !== 1'b1 || busy !== 1'b0 || i2c_done !== 1'b0) begin
        chk("idle_scl", scl, 1);
        chk("idle_sda", sda, 1);
        chk("idle_busy", busy, 0);
        break;
      end
    end
    chk("idle_no_done", done_cnt, 0);
    $display("idle 1000 cycles done");

    xfer(CMD_CTRL, 8'hAE, -1, 0, 1'b0);
    xfer(CMD_CTRL, 8'hAF, -1, 100, 1'b0);
    xfer(DATA_CTRL, 8'h5A, 0, 0, 1'b0);
    xfer(DATA_CTRL, 8'hC3, 1, 0, 1'b0);
    xfer(CMD_CTRL, 8'h81, 2, 0, 1'b0);
    xfer(DATA_CTRL, 8'h18, -1, 0, 1'b1);

    // Reset in the middle of the word-address byte.
    d0 = done_cnt;
    nack_idx = -1;
    word_addr = CMD_CTRL;
    wdata = 8'hA5;
    exec = 1'b1;
    @(negedge clk);
    exec = 1'b0;
    repeat (60 * DIV - 1) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_scl", scl, 1);
    chk("midrst_sda", sda, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", i2c_done, 0);
    rst_n = 1'b1;
    repeat (80 * DIV) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_idle", busy, 0);
    $display("mid-transfer reset done");
    xfer(CMD_CTRL, 8'hA5, -1, 0, 1'b0);

    for (int n = 0; n < 28; n++) begin
      wa = ($urandom_range(0, 1) == 0) ? CMD_CTRL : DATA_CTRL;
      wd = 8'($urandom);
      xfer(wa, wd, -1, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
